// File: rtl/div_sqrt_arb_pkg.sv
// rtl/div_sqrt_arb_pkg.sv - shared types and width constants for the div/sqrt share arbiter
package div_sqrt_arb_pkg;

  localparam int C_DIV_MANT = 23;
  localparam int C_DIV_EXP  = 8;
  localparam int C_DIV_PC   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [C_DIV_MANT:0] mant_a;
    logic [C_DIV_MANT:0] mant_b;
    logic [C_DIV_EXP:0]  exp_a;
    logic [C_DIV_EXP:0]  exp_b;
    logic                sqrt;
    logic [C_DIV_PC-1:0] prec;
  } operand_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin picker, search starts one past the last grant
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx
);

  // Walk the requesters starting after last_grant; first hit wins, last_grant itself is checked last
  always_comb begin
    logic found;
    int   k;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      k = (int'(last_grant) + off) % NUM_REQ;
      if (en && !found && req[k]) begin
        found   = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = IW'(k);
      end
    end
  end

endmodule

// File: rtl/div_sqrt_share_arb.sv
// rtl/div_sqrt_share_arb.sv - shares one iterative div/sqrt unit between requesters (optional watchdog: DIV_SQRT_ARB_TIMEOUT_EN)
module div_sqrt_share_arb #(
  parameter int NUM_REQ     = 2,
  parameter int C_DIV_MANT  = div_sqrt_arb_pkg::C_DIV_MANT,
  parameter int C_DIV_EXP   = div_sqrt_arb_pkg::C_DIV_EXP,
  parameter int C_DIV_PC    = div_sqrt_arb_pkg::C_DIV_PC,
  parameter int TIMEOUT_CYC = 63
) (
  input  logic                              Clk_CI,
  input  logic                              Rst_RBI,
  input  logic [NUM_REQ-1:0]                Req_valid_SI,
  output logic [NUM_REQ-1:0]                Req_ready_SO,
  input  logic [NUM_REQ-1:0]                Req_sqrt_SI,
  input  logic [NUM_REQ*C_DIV_PC-1:0]       Req_prec_DI,
  input  logic [NUM_REQ*(C_DIV_MANT+1)-1:0] Req_mant_a_DI,
  input  logic [NUM_REQ*(C_DIV_MANT+1)-1:0] Req_mant_b_DI,
  input  logic [NUM_REQ*(C_DIV_EXP+1)-1:0]  Req_exp_a_DI,
  input  logic [NUM_REQ*(C_DIV_EXP+1)-1:0]  Req_exp_b_DI,
  output logic [NUM_REQ-1:0]                Rsp_valid_SO,
  input  logic [NUM_REQ-1:0]                Rsp_ready_SI,
  output logic [C_DIV_MANT:0]               Rsp_mant_DO,
  output logic [C_DIV_EXP+1:0]              Rsp_exp_DO,
  output logic                              Rsp_err_SO,
  output logic                              Div_start_SO,
  output logic                              Sqrt_start_SO,
  output logic                              Start_SO,
  output logic [C_DIV_PC-1:0]               Precision_ctl_SO,
  output logic [C_DIV_MANT:0]               Mant_a_DO,
  output logic [C_DIV_MANT:0]               Mant_b_DO,
  output logic [C_DIV_EXP:0]                Exp_a_DO,
  output logic [C_DIV_EXP:0]                Exp_b_DO,
  input  logic                              Unit_ready_SI,
  input  logic                              Unit_done_SI,
  input  logic [C_DIV_MANT:0]               Unit_mant_DI,
  input  logic [C_DIV_EXP+1:0]              Unit_exp_DI
);

  import div_sqrt_arb_pkg::*;

  localparam int MW = C_DIV_MANT + 1;
  localparam int EW = C_DIV_EXP + 1;
  localparam int IW = $clog2(NUM_REQ);

  arb_state_e           state_q, state_d;
  logic [IW-1:0]        last_grant_q, owner_q, gnt_idx;
  logic [NUM_REQ-1:0]   gnt;
  logic                 arb_en, accept, rsp_hs, unit_done_busy, timeout;
  logic                 sqrt_q;
  logic [C_DIV_MANT:0]  rsp_mant_q;
  logic [C_DIV_EXP+1:0] rsp_exp_q;

  assign arb_en         = (state_q == IDLE) && Unit_ready_SI;
  assign accept         = |gnt;
  assign rsp_hs         = (state_q == RESP) && Rsp_ready_SI[owner_q];
  assign unit_done_busy = (state_q == BUSY) && Unit_done_SI;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_arbiter (
    .req        (Req_valid_SI),
    .last_grant (last_grant_q),
    .en         (arb_en),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  assign Req_ready_SO = gnt;
  assign Rsp_mant_DO  = rsp_mant_q;
  assign Rsp_exp_DO   = rsp_exp_q;

`ifdef DIV_SQRT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;

  // Done in the same cycle as the limit takes priority, so the timeout is masked by done
  assign timeout    = (state_q == BUSY) && !Unit_done_SI && (cnt_q == CW'(TIMEOUT_CYC - 1));
  assign Rsp_err_SO = err_q;

  // Watchdog: cleared while issuing so it starts at zero on BUSY entry, counts each BUSY cycle
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == ISSUE)     cnt_q <= '0;
      else if (state_q == BUSY) cnt_q <= cnt_q + 1'b1;
      if (unit_done_busy || rsp_hs) err_q <= 1'b0;
      else if (timeout)             err_q <= 1'b1;
    end
  end
`else
  assign timeout    = 1'b0;
  assign Rsp_err_SO = 1'b0;
`endif

  // State register
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state plus the start pulses and the owner's response valid
  always_comb begin
    state_d       = state_q;
    Start_SO      = 1'b0;
    Div_start_SO  = 1'b0;
    Sqrt_start_SO = 1'b0;
    Rsp_valid_SO  = '0;
    case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: begin
        Start_SO      = 1'b1;
        Div_start_SO  = !sqrt_q;
        Sqrt_start_SO = sqrt_q;
        state_d       = BUSY;
      end
      BUSY:  if (Unit_done_SI || timeout) state_d = RESP;
      RESP: begin
        Rsp_valid_SO[owner_q] = 1'b1;
        if (rsp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture winner operands on accept and hold them until the next accept
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      Mant_a_DO        <= '0;
      Mant_b_DO        <= '0;
      Exp_a_DO         <= '0;
      Exp_b_DO         <= '0;
      Precision_ctl_SO <= '0;
      sqrt_q           <= 1'b0;
      owner_q          <= '0;
    end else if (accept) begin
      Mant_a_DO        <= Req_mant_a_DI[gnt_idx*MW +: MW];
      Mant_b_DO        <= Req_mant_b_DI[gnt_idx*MW +: MW];
      Exp_a_DO         <= Req_exp_a_DI[gnt_idx*EW +: EW];
      Exp_b_DO         <= Req_exp_b_DI[gnt_idx*EW +: EW];
      Precision_ctl_SO <= Req_prec_DI[gnt_idx*C_DIV_PC +: C_DIV_PC];
      sqrt_q           <= Req_sqrt_SI[gnt_idx];
      owner_q          <= gnt_idx;
    end
  end

  // Result capture on done (zeros on watchdog expiry) and round-robin pointer update on handshake
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      rsp_mant_q   <= '0;
      rsp_exp_q    <= '0;
      last_grant_q <= IW'(NUM_REQ - 1);
    end else begin
      if (unit_done_busy) begin
        rsp_mant_q <= Unit_mant_DI;
        rsp_exp_q  <= Unit_exp_DI;
      end else if (timeout) begin
        rsp_mant_q <= '0;
        rsp_exp_q  <= '0;
      end
      if (rsp_hs) last_grant_q <= owner_q;
    end
  end

endmodule

// File: tb/tb_div_sqrt_share_arb.sv
// tb/tb_div_sqrt_share_arb.sv - directed self-checking bench for div_sqrt_share_arb
module tb_div_sqrt_share_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_sqrt, rsp_valid, rsp_ready;
  logic [9:0]  req_prec;
  logic [47:0] req_mant_a, req_mant_b;
  logic [17:0] req_exp_a, req_exp_b;
  logic [23:0] rsp_mant, mant_a, mant_b, unit_mant;
  logic [9:0]  rsp_exp, unit_exp;
  logic        rsp_err, div_start, sqrt_start, start, unit_ready, unit_done;
  logic [4:0]  prec_ctl;
  logic [8:0]  exp_a, exp_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_sqrt_share_arb dut (
    .Clk_CI           (clk),
    .Rst_RBI          (rst_n),
    .Req_valid_SI     (req_valid),
    .Req_ready_SO     (req_ready),
    .Req_sqrt_SI      (req_sqrt),
    .Req_prec_DI      (req_prec),
    .Req_mant_a_DI    (req_mant_a),
    .Req_mant_b_DI    (req_mant_b),
    .Req_exp_a_DI     (req_exp_a),
    .Req_exp_b_DI     (req_exp_b),
    .Rsp_valid_SO     (rsp_valid),
    .Rsp_ready_SI     (rsp_ready),
    .Rsp_mant_DO      (rsp_mant),
    .Rsp_exp_DO       (rsp_exp),
    .Rsp_err_SO       (rsp_err),
    .Div_start_SO     (div_start),
    .Sqrt_start_SO    (sqrt_start),
    .Start_SO         (start),
    .Precision_ctl_SO (prec_ctl),
    .Mant_a_DO        (mant_a),
    .Mant_b_DO        (mant_b),
    .Exp_a_DO         (exp_a),
    .Exp_b_DO         (exp_b),
    .Unit_ready_SI    (unit_ready),
    .Unit_done_SI     (unit_done),
    .Unit_mant_DI     (unit_mant),
    .Unit_exp_DI      (unit_exp)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic s, input logic [23:0] a, input logic [23:0] b,
                         input logic [8:0] ea, input logic [8:0] eb, input logic [4:0] p);
    req_sqrt[r]             = s;
    req_mant_a[r*24 +: 24]  = a;
    req_mant_b[r*24 +: 24]  = b;
    req_exp_a[r*9 +: 9]     = ea;
    req_exp_b[r*9 +: 9]     = eb;
    req_prec[r*5 +: 5]      = p;
  endtask

  // Called at negedge+1 with requests already driven; waits a bounded number of cycles for a grant
  task automatic wait_grant(input string tag, input logic [1:0] exp_gnt);
    for (int i = 0; i < 8; i++) begin
      check_eq("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      if (req_ready != 2'b00) break;
      @(negedge clk); #1;
    end
    check_eq(tag, 64'(req_ready), 64'(exp_gnt));
  endtask

  // From the accept cycle: run issue, a 1-cycle unit, and the response handshake for owner g
  task automatic finish_op(input int g, input logic [23:0] res);
    logic [1:0] oh;
    oh = 2'b01 << g;
    @(negedge clk); #1;
    check_eq("op_start", 64'(start), 64'd1);
    @(negedge clk);
    unit_done = 1'b1; unit_mant = res;
    @(negedge clk);
    unit_done = 1'b0; rsp_ready = oh;
    #1;
    check_eq("op_rsp_valid", 64'(rsp_valid), 64'(oh));
    check_eq("op_rsp_mant", 64'(rsp_mant), 64'(res));
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    check_eq("op_rsp_done", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_sqrt = '0; req_prec = '0;
    req_mant_a = '0; req_mant_b = '0; req_exp_a = '0; req_exp_b = '0;
    rsp_ready = '0; unit_ready = 1'b1; unit_done = 1'b0; unit_mant = '0; unit_exp = '0;
    #12;
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_start", 64'(start), 64'd0);
    check_eq("rst_mant_a", 64'(mant_a), 64'd0);
    check_eq("rst_rsp_mant", 64'(rsp_mant), 64'd0);
    check_eq("rst_rsp_err", 64'(rsp_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single div from requester 0
    @(negedge clk);
    set_req(0, 1'b0, 24'h800000, 24'hC00000, 9'h07F, 9'h080, 5'h10);
    req_valid = 2'b01;
    #1;
    check_eq("t1_accept", 64'(req_ready), 64'h1);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check_eq("t1_start", 64'(start), 64'd1);
    check_eq("t1_div_start", 64'(div_start), 64'd1);
    check_eq("t1_sqrt_start", 64'(sqrt_start), 64'd0);
    check_eq("t1_mant_a", 64'(mant_a), 64'h800000);
    check_eq("t1_mant_b", 64'(mant_b), 64'hC00000);
    check_eq("t1_exp_a", 64'(exp_a), 64'h07F);
    check_eq("t1_ready_issue", 64'(req_ready), 64'd0);
    @(negedge clk);
    unit_done = 1'b1; unit_mant = 24'hAAAAAB; unit_exp = 10'h07F;
    #1;
    check_eq("t1_start_busy", 64'(start), 64'd0);
    check_eq("t1_no_comb_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    unit_done = 1'b0; rsp_ready = 2'b10;
    #1;
    check_eq("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    check_eq("t1_rsp_mant", 64'(rsp_mant), 64'hAAAAAB);
    check_eq("t1_rsp_exp", 64'(rsp_exp), 64'h07F);
    @(negedge clk); #1;
    check_eq("t1_nonowner_hold", 64'(rsp_valid), 64'h1);
    check_eq("t1_mant_hold", 64'(rsp_mant), 64'hAAAAAB);
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    check_eq("t1_rsp_released", 64'(rsp_valid), 64'd0);

    // Sqrt from requester 1, then async reset while BUSY
    set_req(1, 1'b1, 24'h900000, 24'h000000, 9'h081, 9'h000, 5'h17);
    req_valid = 2'b10;
    #1;
    check_eq("t3_accept", 64'(req_ready), 64'h2);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check_eq("t3_sqrt_start", 64'(sqrt_start), 64'd1);
    check_eq("t3_div_start", 64'(div_start), 64'd0);
    check_eq("t3_start", 64'(start), 64'd1);
    check_eq("t3_prec", 64'(prec_ctl), 64'h17);
    check_eq("t3_mant_a", 64'(mant_a), 64'h900000);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_busy_mant_a", 64'(mant_a), 64'd0);
    check_eq("rst_busy_prec", 64'(prec_ctl), 64'd0);
    check_eq("rst_busy_rsp_mant", 64'(rsp_mant), 64'd0);
    check_eq("rst_busy_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesters continuously valid: grants alternate starting at 0
    @(negedge clk);
    set_req(0, 1'b0, 24'h800000, 24'hC00000, 9'h07F, 9'h080, 5'h10);
    set_req(1, 1'b0, 24'hA00000, 24'h800000, 9'h07F, 9'h07F, 5'h10);
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      wait_grant("rr_grant", 2'b01 << (k % 2));
      finish_op(k % 2, 24'h100000 + 24'(k));
    end
    req_valid = 2'b00;

    // Unit busy blocks accept; spurious done in IDLE and ISSUE is ignored
    unit_ready = 1'b0; req_valid = 2'b01;
    #1;
    check_eq("t4_no_accept", 64'(req_ready), 64'd0);
    @(negedge clk);
    unit_done = 1'b1;
    #1;
    check_eq("t4_no_accept2", 64'(req_ready), 64'd0);
    @(negedge clk);
    unit_done = 1'b0;
    #1;
    check_eq("t4_spurious_idle", 64'(rsp_valid), 64'd0);
    unit_ready = 1'b1;
    #1;
    check_eq("t4_accept", 64'(req_ready), 64'h1);
    @(negedge clk);
    req_valid = 2'b00; unit_done = 1'b1;
    #1;
    check_eq("t4_start", 64'(start), 64'd1);
    @(negedge clk);
    unit_done = 1'b0;
    #1;
    check_eq("t4_spurious_issue", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    unit_done = 1'b1; unit_mant = 24'h555555;
    @(negedge clk);
    unit_done = 1'b0;
    #1;
    check_eq("t4_rsp_valid", 64'(rsp_valid), 64'h1);
    check_eq("t4_rsp_mant", 64'(rsp_mant), 64'h555555);
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;

    // Request dropped before it could be granted
    unit_ready = 1'b0; req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b00; unit_ready = 1'b1;
    #1;
    check_eq("t5_drop_no_grant", 64'(req_ready), 64'd0);
    @(negedge clk); #1;
    check_eq("t5_drop_no_start", 64'(start), 64'd0);

`ifdef DIV_SQRT_ARB_TIMEOUT_EN
    // Unit never finishes: error response after 63 BUSY cycles
    req_valid = 2'b01;
    #1;
    check_eq("to_accept", 64'(req_ready), 64'h1);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (63) @(negedge clk);
    #1;
    check_eq("to_not_yet", 64'(rsp_valid), 64'd0);
    @(negedge clk); #1;
    check_eq("to_valid", 64'(rsp_valid), 64'h1);
    check_eq("to_err", 64'(rsp_err), 64'd1);
    check_eq("to_mant_zero", 64'(rsp_mant), 64'd0);
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    check_eq("to_err_cleared", 64'(rsp_err), 64'd0);

    // Done exactly on the limit cycle wins over the timeout
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (63) @(negedge clk);
    unit_done = 1'b1; unit_mant = 24'h123456;
    @(negedge clk);
    unit_done = 1'b0;
    #1;
    check_eq("to_edge_valid", 64'(rsp_valid), 64'h1);
    check_eq("to_edge_err", 64'(rsp_err), 64'd0);
    check_eq("to_edge_mant", 64'(rsp_mant), 64'h123456);
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
`else
    check_eq("no_timeout_err", 64'(rsp_err), 64'd0);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
